b1_boc_code_gen: RTL and testbench
==================================

// Module: b1_boc_code_gen
// PURPOSE
// Local BOC replica generator feeding the B1 tracking correlator. Steps a 32-bit code NCO from
// the loop filter's code frequency control word and runs the G1/G2 11-stage Gold-code LFSRs.
// Applies a square-wave BOC subcarrier and emits early, prompt and late replica bits, plus a
// one-cycle epoch strobe aligned to the prompt replica for integrate-and-dump.
// PARAMETERS
// CODE_LEN   2046          chips per code epoch (chip counter wraps CODE_LEN-1 -> 0)
// G2_TAP_A   1             first G2 stage (1..11) XORed into the G2 output (PRN phase select)
// G2_TAP_B   3             second G2 stage (1..11) XORed into the G2 output
// SPACING    4             E-P and P-L delay in rx_clk cycles, 1..16
// BOC_EN     1             1: XOR square subcarrier into code; 0: plain BPSK replica
// PORTS
// rx_clk        in   1   processing clock, all logic on rising edge
// rx_rst        in   1   synchronous reset, active-low
// rx_start      in   1   one-cycle pulse: (re)start code generation at chip 0
// rx_prn_fcw    in   32  half-chip-rate FCW = f_halfchip/f_clk*2^32 (from loop filter tx_prn_fcw)
// tx_loc_bocE   out  1   early replica bit (1 = -1, 0 = +1)
// tx_loc_bocP   out  1   prompt replica bit = tx_loc_bocE delayed SPACING cycles
// tx_loc_bocL   out  1   late replica bit = tx_loc_bocE delayed 2*SPACING cycles
// tx_prn_sop    out  1   one-cycle pulse on first cycle of chip 0 on the prompt replica
// tx_chip_cnt   out  11  current chip index of the early replica, 0..CODE_LEN-1
// tx_epoch_cnt  out  16  number of completed early-replica epochs since start, wraps at 2^16
// tx_busy       out  1   1 in RUN state
// BEHAVIOUR
// Reset (rx_rst==0 at a clock edge): state IDLE, NCO phase 0, G1=G2=11'b01010101010,
//   chip_cnt 0, epoch_cnt 0, subcarrier 0, delay line all 0; every output 0 next cycle.
// FSM IDLE: NCO, LFSRs and counters frozen; outputs 0. rx_start -> RUN.
// FSM RUN: rx_start -> re-init (same values as reset, delay line cleared), stay RUN.
//   Restart takes priority over any tick in the same cycle. rx_rst overrides everything.
// NCO (RUN): phase <= phase + rx_prn_fcw, 32-bit wrap. Carry-out = half-chip tick (max 1/cycle).
//   FCW is sampled every cycle; a change applies on the next add. FCW 0 -> replica frozen, no sop.
// Half-chip tick: toggle subcarrier. When subcarrier returns to 0, it is a chip tick:
//   step G1 (1+x+x7+x8+x9+x10+x11), step G2 (1+x+x2+x3+x4+x5+x8+x9+x11), chip_cnt+1.
//   chip_cnt==CODE_LEN-1 on chip tick: chip_cnt<=0, G1,G2 reload init (truncated code), epoch_cnt+1.
// Code bit = G1[11] ^ G2[G2_TAP_A] ^ G2[G2_TAP_B]. E = code ^ (BOC_EN ? subcarrier : 0).
// Early outputs are registered. The cycle after rx_start shows chip 0, first half, sop_E=1.
// sop_E = 1 for exactly the first cycle of each chip 0 on E, including the epoch right after start.
// Delay line depth 2*SPACING carries {E, sop_E}. P and tx_prn_sop use tap SPACING; L uses tap 2*SPACING.
//   During the first SPACING / 2*SPACING cycles after start, P and L output the cleared 0.
// Latency: rx_start at edge n -> tx_loc_bocE chip0 at n+1; tx_prn_sop at n+1+SPACING.
// tx_chip_cnt, tx_epoch_cnt and tx_busy are registered and follow E timing.
// TESTING
// T1 FCW=32'h8000_0000, start: E chip every 4 cycles, subcarrier flips every 2; tx_prn_sop
//    period 8184 cycles; first sop 1+SPACING cycles after start.
// T2 SPACING=4, random FCW: tx_loc_bocP(t)==tx_loc_bocE(t-4) and tx_loc_bocL(t)==tx_loc_bocE(t-8)
//    every cycle after cycle 8.
// T3 BOC_EN=0, FCW=32'h8000_0000, 3 epochs: E chip sequence matches the bit-exact golden G1/G2
//    model for taps (1,3). The sequence repeats identically each epoch, and tx_epoch_cnt reads 3.
// T4 rx_rst=0 mid-RUN at chip 700: all outputs 0 next cycle, tx_busy 0. rx_start -> chip 0 restart.
// T5 rx_start pulsed at chip 1000 in RUN: tx_chip_cnt 0 next cycle, delay line cleared,
//    tx_prn_sop exactly SPACING+1 cycles later, and no stale sop from the old epoch.
// T6 FCW switched to 0 mid-epoch: all outputs hold last values, no sop. FCW restored:
//    the sequence resumes from the held chip/half-chip.

Source files
------------

// File: rtl/b1_boc_code_gen.sv
// B1 BOC local replica generator: half-chip code NCO, G1/G2 Gold-code LFSRs, square BOC
// subcarrier, early/prompt/late replica taps and a prompt-aligned epoch strobe.

module b1_boc_code_gen #(
  parameter int unsigned CODE_LEN = 2046,
  parameter int unsigned G2_TAP_A = 1,
  parameter int unsigned G2_TAP_B = 3,
  parameter int unsigned SPACING  = 4,
  parameter bit          BOC_EN   = 1'b1
) (
  input  logic        rx_clk,
  input  logic        rx_rst,
  input  logic        rx_start,
  input  logic [31:0] rx_prn_fcw,
  output logic        tx_loc_bocE,
  output logic        tx_loc_bocP,
  output logic        tx_loc_bocL,
  output logic        tx_prn_sop,
  output logic [10:0] tx_chip_cnt,
  output logic [15:0] tx_epoch_cnt,
  output logic        tx_busy
);

  localparam int unsigned DEPTH     = 2 * SPACING;
  localparam logic [11:1] LFSR_INIT = 11'b01010101010;
  localparam logic [10:0] LAST_CHIP = 11'(CODE_LEN - 1);
  localparam logic [3:0]  TAP_A     = 4'(G2_TAP_A);
  localparam logic [3:0]  TAP_B     = 4'(G2_TAP_B);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // One delay-line slot: replica bit plus its epoch strobe, so P and its sop stay aligned.
  typedef struct packed {
    logic e;
    logic sop;
  } tap_t;

  // Fibonacci LFSRs: stage 1 takes the feedback, stage 11 is the oldest bit.
  function automatic logic [11:1] g1_step(input logic [11:1] g);
    return {g[10:1], g[1] ^ g[7] ^ g[8] ^ g[9] ^ g[10] ^ g[11]};
  endfunction

  function automatic logic [11:1] g2_step(input logic [11:1] g);
    return {g[10:1], g[1] ^ g[2] ^ g[3] ^ g[4] ^ g[5] ^ g[8] ^ g[9] ^ g[11]};
  endfunction

  state_t      state_q, state_d;
  logic [31:0] phase_q, phase_d;
  logic [11:1] g1_q, g1_d;
  logic [11:1] g2_q, g2_d;
  logic [10:0] chip_q, chip_d;
  logic [15:0] epoch_q, epoch_d;
  logic        sub_q, sub_d;
  logic        e_q, e_d;
  logic        sop_q, sop_d;
  tap_t        dl_q [DEPTH];
  tap_t        dl_d [DEPTH];

  logic [32:0] nco_sum;
  logic        half_tick;
  logic        chip_tick;
  logic        code_bit;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    phase_d   = phase_q;
    g1_d      = g1_q;
    g2_d      = g2_q;
    chip_d    = chip_q;
    epoch_d   = epoch_q;
    sub_d     = sub_q;
    sop_d     = 1'b0;
    dl_d      = dl_q;
    nco_sum   = {1'b0, phase_q} + {1'b0, rx_prn_fcw};
    half_tick = 1'b0;
    chip_tick = 1'b0;

    if (rx_start) begin
      // Restart wins over any NCO carry in the same cycle.
      state_d = RUN;
      phase_d = '0;
      g1_d    = LFSR_INIT;
      g2_d    = LFSR_INIT;
      chip_d  = '0;
      epoch_d = '0;
      sub_d   = 1'b0;
      sop_d   = 1'b1;
      for (int i = 0; i < DEPTH; i++) dl_d[i] = '0;
    end else if (state_q == RUN) begin
      phase_d   = nco_sum[31:0];
      half_tick = nco_sum[32];
      chip_tick = half_tick & sub_q;
      dl_d[0]   = {e_q, sop_q};
      for (int i = 1; i < DEPTH; i++) dl_d[i] = dl_q[i-1];
      if (half_tick) sub_d = ~sub_q;
      if (chip_tick) begin
        if (chip_q == LAST_CHIP) begin
          // Truncated code: both registers reload at the epoch boundary.
          chip_d  = '0;
          g1_d    = LFSR_INIT;
          g2_d    = LFSR_INIT;
          epoch_d = epoch_q + 16'd1;
          sop_d   = 1'b1;
        end else begin
          chip_d = chip_q + 11'd1;
          g1_d   = g1_step(g1_q);
          g2_d   = g2_step(g2_q);
        end
      end
    end

    code_bit = g1_d[11] ^ g2_d[TAP_A] ^ g2_d[TAP_B];
    e_d      = (state_d == RUN) & (code_bit ^ (BOC_EN & sub_d));
  end

  always_ff @(posedge rx_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rx_rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      g1_q    <= LFSR_INIT;
      g2_q    <= LFSR_INIT;
      chip_q  <= '0;
      epoch_q <= '0;
      sub_q   <= 1'b0;
      e_q     <= 1'b0;
      sop_q   <= 1'b0;
      // NOTE: the delay line is a memory that must be reset, since P/L read 0 straight out of reset.
      for (int i = 0; i < DEPTH; i++) dl_q[i] <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      g1_q    <= g1_d;
      g2_q    <= g2_d;
      chip_q  <= chip_d;
      epoch_q <= epoch_d;
      sub_q   <= sub_d;
      e_q     <= e_d;
      sop_q   <= sop_d;
      dl_q    <= dl_d;
    end
  end

  assign tx_loc_bocE  = e_q;
  assign tx_loc_bocP  = dl_q[SPACING-1].e;
  assign tx_loc_bocL  = dl_q[DEPTH-1].e;
  assign tx_prn_sop   = dl_q[SPACING-1].sop;
  assign tx_chip_cnt  = chip_q;
  assign tx_epoch_cnt = epoch_q;
  assign tx_busy      = (state_q == RUN);

endmodule

// File: tb/tb_b1_boc_code_gen.sv
// Randomized self-checking bench for b1_boc_code_gen against a half-chip-count reference model
// (total NCO accumulation -> half-chip index -> chip/subcarrier/epoch, golden code table).

module tb_b1_boc_code_gen;

  localparam int          S              = 4;
  localparam int          CODE_LEN       = 2046;
  localparam int          HALF_PER_EPOCH = 2 * CODE_LEN;
  localparam logic [31:0] HALF_FCW       = 32'h8000_0000;

  logic        rx_clk = 1'b0;
  logic        rx_rst;
  logic        rx_start;
  logic [31:0] rx_prn_fcw;

  logic        e, p, l, sop, busy;
  logic [10:0] chip;
  logic [15:0] epoch;
  logic        b_e, b_p, b_l, b_sop, b_busy;
  logic [10:0] b_chip;
  logic [15:0] b_epoch;
  logic [31:0] obs;

  assign obs = {e, p, l, sop, busy, chip, epoch};

  b1_boc_code_gen #(.CODE_LEN(2046), .G2_TAP_A(1), .G2_TAP_B(3), .SPACING(S), .BOC_EN(1'b1)) dut (
    .rx_clk(rx_clk), .rx_rst(rx_rst), .rx_start(rx_start), .rx_prn_fcw(rx_prn_fcw),
    .tx_loc_bocE(e), .tx_loc_bocP(p), .tx_loc_bocL(l), .tx_prn_sop(sop),
    .tx_chip_cnt(chip), .tx_epoch_cnt(epoch), .tx_busy(busy)
  );

  b1_boc_code_gen #(.CODE_LEN(2046), .G2_TAP_A(1), .G2_TAP_B(3), .SPACING(S), .BOC_EN(1'b0)) dut_bpsk (
    .rx_clk(rx_clk), .rx_rst(rx_rst), .rx_start(rx_start), .rx_prn_fcw(rx_prn_fcw),
    .tx_loc_bocE(b_e), .tx_loc_bocP(b_p), .tx_loc_bocL(b_l), .tx_prn_sop(b_sop),
    .tx_chip_cnt(b_chip), .tx_epoch_cnt(b_epoch), .tx_busy(b_busy)
  );

  always #5 rx_clk = ~rx_clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: golden code table plus total accumulated phase since start.
  bit              code [CODE_LEN];
  bit              m_run;
  longint unsigned m_acc;
  logic [1:0]      m_log[$];

  function automatic void build_code();
    bit g1 [1:11];
    bit g2 [1:11];
    bit f1, f2;
    for (int s = 1; s <= 11; s++) begin
      g1[s] = (s % 2 == 0);
      g2[s] = (s % 2 == 0);
    end
    for (int k = 0; k < CODE_LEN; k++) begin
      code[k] = g1[11] ^ g2[1] ^ g2[3];
      f1 = g1[1] ^ g1[7] ^ g1[8] ^ g1[9] ^ g1[10] ^ g1[11];
      f2 = g2[1] ^ g2[2] ^ g2[3] ^ g2[4] ^ g2[5] ^ g2[8] ^ g2[9] ^ g2[11];
      for (int s = 11; s >= 2; s--) begin
        g1[s] = g1[s-1];
        g2[s] = g2[s-1];
      end
      g1[1] = f1;
      g2[1] = f2;
    end
  endfunction

  function automatic longint unsigned m_half();
    return m_acc >> 32;
  endfunction

  function automatic int m_chip();
    return int'((m_half() >> 1) % CODE_LEN);
  endfunction

  function automatic bit m_e(input bit boc);
    longint unsigned h;
    h = m_half();
    return m_run ? (code[m_chip()] ^ (boc & h[0])) : 1'b0;
  endfunction

  function automatic void model_update(input bit st, input logic [31:0] f, input bit rst_v);
    longint unsigned h0, h1;
    bit sop_e;
    if (!rst_v) begin
      m_run = 1'b0;
      m_acc = 0;
      m_log.delete();
      return;
    end
    if (st) begin
      m_run = 1'b1;
      m_acc = 0;
      m_log.delete();
      sop_e = 1'b1;
    end else if (m_run) begin
      h0    = m_half();
      m_acc = m_acc + 64'(f);
      h1    = m_half();
      sop_e = (h1 != h0) && (h1 % HALF_PER_EPOCH == 0);
    end else begin
      return;
    end
    m_log.push_back({m_e(1'b1), sop_e});
    if (m_log.size() > 2 * S + 1) void'(m_log.pop_front());
  endfunction

  function automatic logic [31:0] exp_vec();
    logic [1:0] pt, lt;
    int n;
    n  = m_log.size();
    pt = (n > S) ? m_log[n-1-S] : 2'b00;
    lt = (n > 2 * S) ? m_log[n-1-2*S] : 2'b00;
    return {m_e(1'b1), pt[1], lt[1], pt[0], m_run, 11'(m_chip()),
            16'((m_half() / HALF_PER_EPOCH) % 65536)};
  endfunction

  // Drive one cycle: inputs set away from the edge, model advanced at the edge, sample at negedge.
  task automatic step(input bit st, input logic [31:0] f, input bit rst_v);
    rx_start   = st;
    rx_prn_fcw = f;
    rx_rst     = rst_v;
    @(posedge rx_clk);
    model_update(st, f, rst_v);
    @(negedge rx_clk);
    rx_start = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    checks++;
    if (obs !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=%h", obs, 32'h0);
    end
    checks++;
    if (b_e !== 1'b0 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_bpsk got=%b%b exp=00", b_e, b_busy);
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, $urandom(), 1'b1);
      checks++;
      if (obs !== 32'h0) begin
        errors++;
        $display("FAIL idle_frozen k=%0d got=%h exp=%h", k, obs, 32'h0);
      end
    end
  endtask

  task automatic test_half_rate();
    int first_sop = -1;
    int second_sop = -1;
    for (int k = 0; k <= S + 8184 + 3; k++) begin
      step(k == 0, HALF_FCW, 1'b1);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL t1_vec k=%0d got=%h exp=%h", k, obs, exp_vec());
        break;
      end
      if (sop === 1'b1) begin
        if (first_sop < 0) first_sop = k;
        else if (second_sop < 0) second_sop = k;
      end
    end
    checks++;
    if (first_sop != S) begin
      errors++;
      $display("FAIL t1_first_sop got=%0d exp=%0d", first_sop, S);
    end
    checks++;
    if (second_sop - first_sop != 8184) begin
      errors++;
      $display("FAIL t1_sop_period got=%0d exp=%0d", second_sop - first_sop, 8184);
    end
  endtask

  task automatic test_spacing();
    logic [31:0] f;
    f = $urandom();
    for (int k = 0; k < 400; k++) begin
      if (k % 37 == 36) f = (k == 147) ? 32'hFFFF_FFFF : $urandom();
      step(k == 0, f, 1'b1);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL t2_vec k=%0d fcw=%h got=%h exp=%h", k, f, obs, exp_vec());
        break;
      end
    end
  endtask

  task automatic test_epochs_bpsk();
    for (int k = 0; k <= 3 * 8184; k++) begin
      step(k == 0, HALF_FCW, 1'b1);
      checks++;
      if (b_e !== m_e(1'b0) || b_chip !== 11'(m_chip())) begin
        errors++;
        $display("FAIL t3_bpsk k=%0d got=%b/%0d exp=%b/%0d", k, b_e, b_chip, m_e(1'b0), m_chip());
        break;
      end
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL t3_vec k=%0d got=%h exp=%h", k, obs, exp_vec());
        break;
      end
    end
    checks++;
    if (b_epoch !== 16'd3 || b_chip !== 11'd0) begin
      errors++;
      $display("FAIL t3_epoch_cnt got=%0d/%0d exp=3/0", b_epoch, b_chip);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] f;
    f = 32'h8000_0000 | $urandom();
    step(1'b1, f, 1'b1);
    for (int k = 1; k < 4000 && m_chip() < 700; k++) begin
      step(1'b0, f, 1'b1);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL t4_run k=%0d got=%h exp=%h", k, obs, exp_vec());
        break;
      end
    end
    checks++;
    if (chip !== 11'd700) begin
      errors++;
      $display("FAIL t4_reach_700 got=%0d exp=700", chip);
    end
    step(1'b0, f, 1'b0);
    checks++;
    if (obs !== 32'h0) begin
      errors++;
      $display("FAIL t4_reset_out got=%h exp=%h", obs, 32'h0);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, f, 1'b1);
      checks++;
      if (obs !== 32'h0) begin
        errors++;
        $display("FAIL t4_idle k=%0d got=%h exp=%h", k, obs, 32'h0);
      end
    end
    step(1'b1, f, 1'b1);
    checks++;
    if (chip !== 11'd0 || busy !== 1'b1 || e !== code[0]) begin
      errors++;
      $display("FAIL t4_restart got=%0d/%b/%b exp=0/1/%b", chip, busy, e, code[0]);
    end
    for (int k = 1; k < 20; k++) begin
      step(1'b0, f, 1'b1);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL t4_after k=%0d got=%h exp=%h", k, obs, exp_vec());
        break;
      end
    end
  endtask

  task automatic test_restart();
    logic [31:0] f;
    f = 32'hC000_0000 | $urandom();
    step(1'b1, f, 1'b1);
    for (int k = 1; k < 4000 && m_chip() < 1000; k++) begin
      step(1'b0, f, 1'b1);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL t5_run k=%0d got=%h exp=%h", k, obs, exp_vec());
        break;
      end
    end
    step(1'b1, f, 1'b1);
    checks++;
    if (chip !== 11'd0 || p !== 1'b0 || l !== 1'b0) begin
      errors++;
      $display("FAIL t5_restart got=%0d/%b/%b exp=0/0/0", chip, p, l);
    end
    for (int k = 1; k <= 2 * S + 1; k++) begin
      step(1'b0, f, 1'b1);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL t5_vec k=%0d got=%h exp=%h", k, obs, exp_vec());
      end
      checks++;
      if (sop !== (k == S)) begin
        errors++;
        $display("FAIL t5_sop k=%0d got=%b exp=%b", k, sop, (k == S));
      end
    end
    // Back-to-back restart with the first start's strobe still inside the delay line.
    step(1'b1, f, 1'b1);
    step(1'b0, f, 1'b1);
    step(1'b0, f, 1'b1);
    step(1'b1, f, 1'b1);
    for (int k = 1; k <= S + 2; k++) begin
      step(1'b0, f, 1'b1);
      checks++;
      if (sop !== (k == S)) begin
        errors++;
        $display("FAIL t5_stale_sop k=%0d got=%b exp=%b", k, sop, (k == S));
      end
    end
  endtask

  task automatic test_freeze();
    logic [31:0] f;
    f = 32'hA000_0000 | $urandom();
    for (int k = 0; k < 300; k++) begin
      step(k == 0, f, 1'b1);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL t6_pre k=%0d got=%h exp=%h", k, obs, exp_vec());
        break;
      end
    end
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 32'h0, 1'b1);
      checks++;
      if (obs !== exp_vec() || sop !== 1'b0) begin
        errors++;
        $display("FAIL t6_hold k=%0d got=%h exp=%h", k, obs, exp_vec());
        break;
      end
    end
    for (int k = 0; k < 300; k++) begin
      step(1'b0, f, 1'b1);
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL t6_resume k=%0d got=%h exp=%h", k, obs, exp_vec());
        break;
      end
    end
  endtask

  initial begin
    repeat (95000) @(posedge rx_clk);
    $display("FAIL watchdog cycles=95000 exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rx_rst     = 1'b0;
    rx_start   = 1'b0;
    rx_prn_fcw = 32'h0;
    m_run      = 1'b0;
    m_acc      = 0;
    build_code();
    test_reset();
    test_half_rate();
    test_spacing();
    test_epochs_bpsk();
    test_reset_mid();
    test_restart();
    test_freeze();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
